// File: rtl/cbm2_bus_sequencer_if.sv
// Bus-side signal bundle for the CBM-II bus-frame sequencer.
// Master is the bus logic/CPU side. Slave is the sequencer.
interface cbm2_bus_sequencer_if;
    logic cpu_we;
    logic ba;
    logic cs_ram;
    logic phi0;
    logic cpu_has_bus;
    logic wr_io_pulse;
    logic ram_ce;
    logic ram_we;

    modport master (
        output cpu_we, ba, cs_ram,
        input  phi0, cpu_has_bus, wr_io_pulse, ram_ce, ram_we
    );

    modport slave (
        input  cpu_we, ba, cs_ram,
        output phi0, cpu_has_bus, wr_io_pulse, ram_ce, ram_we
    );
endinterface

// File: rtl/cbm2_bus_sequencer.sv
// CBM-II bus-frame sequencer: slot counter, phase enables, bus strobes, SDRAM refresh and frame-aligned reset.
// Defining CBM2_SEQ_TURBO_EN adds the turbo port (4 CPU enables per frame).
module cbm2_bus_sequencer #(
    parameter int SLOTS     = 32,
    parameter int EXT_SLOTS = 12,
    parameter int VID_SLOTS = 4,
    parameter int RFSH_DIV  = 4,
    parameter int RFSH_SLOT = 4,
    parameter int RFSH_LEN  = 4,
    parameter int PIX_PHASE = 1
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        req_reset,
    input  logic                        model,
`ifdef CBM2_SEQ_TURBO_EN
    input  logic                        turbo,
`endif
    cbm2_bus_sequencer_if.slave         bus,
    output logic [$clog2(SLOTS)-1:0]    slot,
    output logic [$clog2(RFSH_DIV):0]   frame_cnt,
    output logic                        io_cycle,
    output logic                        vid_cycle,
    output logic                        cpu_cycle,
    output logic                        en_cpu,
    output logic                        en_vic,
    output logic                        en_io_p,
    output logic                        en_io_n,
    output logic                        en_pix,
    output logic                        refresh,
    output logic                        core_reset
);
    localparam int SW = $clog2(SLOTS);
    localparam int FW = $clog2(RFSH_DIV) + 1;
    localparam int C0 = EXT_SLOTS + VID_SLOTS;
    localparam int NC = SLOTS - C0;

    if (NC < 8 || (NC % 4) != 0) begin : g_bad_nc
        $error("cbm2_bus_sequencer: CPU region must be >= 8 slots and a multiple of 4");
    end
    if (SLOTS < 16 || SLOTS > 64 || (SLOTS & (SLOTS - 1)) != 0) begin : g_bad_slots
        $error("cbm2_bus_sequencer: SLOTS must be a power of 2 in 16..64");
    end
    if (RFSH_DIV < 1 || RFSH_SLOT < 1 || RFSH_SLOT + RFSH_LEN > EXT_SLOTS) begin : g_bad_rfsh
        $error("cbm2_bus_sequencer: refresh window must lie inside the EXT region");
    end

    logic turbo_q;
    int   s;

    assign s = int'(slot);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            slot            <= '0;
            frame_cnt       <= '0;
            core_reset      <= 1'b0;
            refresh         <= 1'b0;
            turbo_q         <= 1'b0;
            bus.phi0        <= 1'b0;
            bus.cpu_has_bus <= 1'b0;
            bus.wr_io_pulse <= 1'b0;
        end else begin
            slot            <= slot + SW'(1);
            bus.wr_io_pulse <= bus.cpu_we && (s == SLOTS - 4);
            // Registered one slot early so refresh lands exactly on RFSH_SLOT.
            refresh         <= (s == RFSH_SLOT - 1) && (frame_cnt == '0);
            if (s == C0 - 1) begin
                bus.phi0        <= 1'b1;
                bus.cpu_has_bus <= bus.ba | bus.cpu_we;
            end
            if (s == SLOTS - 1) begin
                bus.phi0        <= 1'b0;
                bus.cpu_has_bus <= 1'b0;
                core_reset      <= req_reset;
                frame_cnt       <= (frame_cnt == FW'(RFSH_DIV - 1)) ? '0 : frame_cnt + FW'(1);
`ifdef CBM2_SEQ_TURBO_EN
                turbo_q         <= turbo;
`else
                turbo_q         <= 1'b0;
`endif
            end
        end
    end

    always_comb begin
        cpu_cycle  = (s >= C0);
        vid_cycle  = (s >= EXT_SLOTS && s < C0) || (s >= SLOTS - 4);
        io_cycle   = (s < EXT_SLOTS) &&
                     !((frame_cnt == '0) && s >= RFSH_SLOT && s < RFSH_SLOT + RFSH_LEN);
        en_cpu     = (s == C0 + 3) ||
                     ((model || turbo_q) && s == C0 + NC / 2 + 3) ||
                     (turbo_q && (s == C0 + NC / 4 + 3 || s == C0 + 3 * NC / 4 + 3));
        en_vic     = (s == C0 - 1) || (s == SLOTS - 1);
        en_io_p    = (s == SLOTS - 3);
        en_io_n    = (s == 0);
        en_pix     = (slot[1:0] == 2'(PIX_PHASE));
        bus.ram_ce = bus.cs_ram && ((!model && s == EXT_SLOTS) || s == C0);
        bus.ram_we = bus.cpu_we && cpu_cycle;
    end
endmodule

// File: tb/tb_cbm2_bus_sequencer.sv
// Self-checking bench for cbm2_bus_sequencer: directed frame scenarios plus random stimulus
// against a frame-arithmetic reference model.
module tb_cbm2_bus_sequencer;
    localparam int SLOTS     = 32;
    localparam int EXT_SLOTS = 12;
    localparam int VID_SLOTS = 4;
    localparam int RFSH_DIV  = 4;
    localparam int RFSH_SLOT = 4;
    localparam int RFSH_LEN  = 4;
    localparam int PIX_PHASE = 1;
    localparam int C0 = EXT_SLOTS + VID_SLOTS;
    localparam int NC = SLOTS - C0;
    localparam int SW = $clog2(SLOTS);
    localparam int FW = $clog2(RFSH_DIV) + 1;

    logic clk_sys   = 1'b0;
    logic reset     = 1'b1;
    logic req_reset = 1'b0;
    logic model     = 1'b0;
`ifdef CBM2_SEQ_TURBO_EN
    logic turbo     = 1'b0;
`endif
    logic [SW-1:0] slot;
    logic [FW-1:0] frame_cnt;
    logic io_cycle, vid_cycle, cpu_cycle, en_cpu, en_vic, en_io_p, en_io_n, en_pix;
    logic refresh, core_reset;

    cbm2_bus_sequencer_if bus ();

    cbm2_bus_sequencer #(
        .SLOTS(SLOTS), .EXT_SLOTS(EXT_SLOTS), .VID_SLOTS(VID_SLOTS), .RFSH_DIV(RFSH_DIV),
        .RFSH_SLOT(RFSH_SLOT), .RFSH_LEN(RFSH_LEN), .PIX_PHASE(PIX_PHASE)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .req_reset(req_reset), .model(model),
`ifdef CBM2_SEQ_TURBO_EN
        .turbo(turbo),
`endif
        .bus(bus.slave), .slot(slot), .frame_cnt(frame_cnt),
        .io_cycle(io_cycle), .vid_cycle(vid_cycle), .cpu_cycle(cpu_cycle),
        .en_cpu(en_cpu), .en_vic(en_vic), .en_io_p(en_io_p), .en_io_n(en_io_n), .en_pix(en_pix),
        .refresh(refresh), .core_reset(core_reset)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int passed = 0;
    // Reference model: clocks since reset release, plus values latched at frame positions.
    int   k = 0;
    logic grant_m = 1'b0;   // ba|cpu_we seen at slot C0-1 of this frame
    logic we_m = 1'b0;      // cpu_we seen on the slot before (only meaningful at SLOTS-4)
    logic creset_m = 1'b0;  // req_reset seen at the last slot of the previous frame
    logic turbo_m = 1'b0;   // turbo seen at the last slot of the previous frame

    task automatic cycle();
        int s, f, c;
        logic [14:0] exp_v, act_v;
        logic rst_now, tb_turbo;
        @(negedge clk_sys);
        s = k % SLOTS;
        f = (k / SLOTS) % RFSH_DIV;
        c = s - C0;
        exp_v = {
            (s < EXT_SLOTS) && !(f == 0 && s >= RFSH_SLOT && s < RFSH_SLOT + RFSH_LEN),
            (s >= EXT_SLOTS && s < C0) || (c >= NC - 4),
            (s >= C0),
            (c == 3) || ((model || turbo_m) && c == NC / 2 + 3) ||
                (turbo_m && (c == NC / 4 + 3 || c == 3 * NC / 4 + 3)),
            (s == C0 - 1) || (c == NC - 1),
            (c == NC - 3),
            (s == 0),
            (s % 4 == PIX_PHASE),
            we_m,
            (s >= C0),
            (s >= C0) && grant_m,
            bus.cs_ram && ((!model && s == EXT_SLOTS) || s == C0),
            bus.cpu_we && (s >= C0),
            (s == RFSH_SLOT) && (f == 0),
            creset_m
        };
        act_v = {io_cycle, vid_cycle, cpu_cycle, en_cpu, en_vic, en_io_p, en_io_n, en_pix,
                 bus.wr_io_pulse, bus.phi0, bus.cpu_has_bus, bus.ram_ce, bus.ram_we, refresh, core_reset};
        checks++;
        if (slot !== SW'(s)) $display("FAIL slot k=%0d actual=%0d expected=%0d", k, slot, s);
        else passed++;
        checks++;
        if (frame_cnt !== FW'(f)) $display("FAIL frame_cnt k=%0d actual=%0d expected=%0d", k, frame_cnt, f);
        else passed++;
        checks++;
        if (act_v !== exp_v)
            $display("FAIL outputs slot=%0d frame=%0d actual=%b expected=%b", s, f, act_v, exp_v);
        else passed++;
`ifdef CBM2_SEQ_TURBO_EN
        tb_turbo = turbo;
`else
        tb_turbo = 1'b0;
`endif
        if (s == C0 - 1) grant_m = bus.ba | bus.cpu_we;
        we_m = (s == SLOTS - 4) && bus.cpu_we;
        if (s == SLOTS - 1) begin
            creset_m = req_reset;
            turbo_m  = tb_turbo;
        end
        rst_now = reset;
        @(posedge clk_sys);
        #1;
        if (rst_now) begin
            k = 0; grant_m = 1'b0; we_m = 1'b0; creset_m = 1'b0; turbo_m = 1'b0;
        end else begin
            k++;
        end
    endtask

    task automatic run_to(input int n);
        for (int i = 0; i < 2 * SLOTS && (k % SLOTS) != n; i++) cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b0;
    endtask

    task automatic test_model0_frame();
        run_to(0);
        model = 1'b0; bus.cs_ram = 1'b1; bus.ba = 1'b1; bus.cpu_we = 1'b0;
        for (int i = 0; i < SLOTS; i++) cycle();
    endtask

    task automatic test_model1_frame();
        model = 1'b1;
        for (int i = 0; i < SLOTS; i++) cycle();
        model = 1'b0;
    endtask

    task automatic test_refresh();
        for (int i = 0; i < 8 * SLOTS; i++) begin
            bus.cs_ram = 1'($urandom_range(0, 1));
            bus.ba     = 1'($urandom_range(0, 1));
            cycle();
        end
    endtask

    task automatic test_io_write();
        run_to(0);
        bus.cs_ram = 1'b1;
        for (int i = 0; i < SLOTS; i++) begin
            bus.cpu_we = ((k % SLOTS) == SLOTS - 4);
            cycle();
        end
        bus.cpu_we = 1'b1;
        for (int i = 0; i < SLOTS; i++) cycle();
        bus.cpu_we = 1'b0;
    endtask

    task automatic test_bus_grant();
        run_to(0);
        bus.ba = 1'b0; bus.cpu_we = 1'b0; req_reset = 1'b0;
        for (int i = 0; i < SLOTS; i++) cycle();
        bus.ba = 1'b1;
        for (int i = 0; i < SLOTS; i++) begin
            req_reset = ((k % SLOTS) == SLOTS - 1);
            cycle();
        end
        req_reset = 1'b0;
        for (int i = 0; i < 2 * SLOTS; i++) cycle();
    endtask

    task automatic test_mid_frame_reset();
        run_to(20);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) cycle();
    endtask

`ifdef CBM2_SEQ_TURBO_EN
    task automatic test_turbo();
        run_to(0);
        model = 1'b0; turbo = 1'b1;
        for (int i = 0; i < 3 * SLOTS; i++) cycle();
        turbo = 1'b0;
        for (int i = 0; i < 2 * SLOTS; i++) cycle();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 640; i++) begin
            model      = 1'($urandom_range(0, 1));
            bus.cpu_we = 1'($urandom_range(0, 1));
            bus.ba     = 1'($urandom_range(0, 1));
            bus.cs_ram = 1'($urandom_range(0, 1));
            req_reset  = ($urandom_range(0, 3) == 0);
`ifdef CBM2_SEQ_TURBO_EN
            if ((k % SLOTS) == 0) turbo = 1'($urandom_range(0, 1));
`endif
            reset      = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;
        cycle();
    endtask

    initial begin
        bus.cpu_we = 1'b0; bus.ba = 1'b0; bus.cs_ram = 1'b0;
        @(posedge clk_sys);
        #1;
        test_reset();
        test_model0_frame();
        test_model1_frame();
        test_refresh();
        test_io_write();
        test_bus_grant();
        test_mid_frame_reset();
`ifdef CBM2_SEQ_TURBO_EN
        test_turbo();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
